// File: rtl/regfile_sb.sv
// Register file with byte-enabled writeback, optional write-to-read
// forwarding and a per-register pending-write scoreboard.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    output logic                rd_busy1,
    output logic                rd_busy2,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_addr,
    output logic [ADDR_W:0]     busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   cnt_next;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] wr_merged;
    logic              wr_ok;
    logic              iss_ok;

    logic [ADDR_W-1:0] ra [2];
    logic [DATA_W-1:0] rd [2];
    logic              rb [2];

    assign ra[0]    = rd_addr1;
    assign ra[1]    = rd_addr2;
    assign rd_data1 = rd[0];
    assign rd_data2 = rd[1];
    assign rd_busy1 = rb[0];
    assign rd_busy2 = rb[1];

    // Register 0 swallows writes and issues when it is hard-wired.
    assign wr_ok  = wr_en && ((wr_addr != '0) || (ZERO_REG == 0));
    assign iss_ok = iss_en && ((iss_addr != '0) || (ZERO_REG == 0));

    // Expand byte enables to a bit mask and merge with the stored word.
    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < NB; i++) begin
            wr_mask[8*i +: 8] = {8{wr_be[i]}};
        end
        wr_merged = (regs[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd[p] = regs[ra[p]];
            rb[p] = busy[ra[p]];
            if ((BYPASS != 0) && wr_ok && (wr_addr == ra[p])) begin
                rd[p] = (rd[p] & ~wr_mask) | (wr_data & wr_mask);
                rb[p] = 1'b0;
            end
            if ((ZERO_REG != 0) && (ra[p] == '0)) begin
                rd[p] = '0;
                rb[p] = 1'b0;
            end
        end
    end

    // Scoreboard next state: writeback clears, issue sets and wins ties.
    always_comb begin
        busy_next = busy;
        if (wr_ok) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (iss_ok) begin
            busy_next[iss_addr] = 1'b1;
        end
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + (ADDR_W+1)'(busy_next[i]);
        end
    end

    // Data storage with byte-enabled writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_merged;
        end
    end

    // Busy bits and their registered population count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: two instances (default and
// ZERO_REG=0/BYPASS=0) checked against an array-based reference model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr1, rd_addr2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        iss_en;
    logic [4:0]  iss_addr;

    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_bz1, a_bz2, b_bz1, b_bz2;
    logic [5:0]  a_cnt, b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    bit [31:0] m_mem  [2][32];
    bit        m_busy [2][32];
    bit        zr [2] = '{1'b1, 1'b0};
    bit        by [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    regfile_sb dut_a (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(a_rd1), .rd_data2(a_rd2),
        .rd_busy1(a_bz1), .rd_busy2(a_bz2),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_cnt(a_cnt)
    );

    regfile_sb #(.ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(b_rd1), .rd_data2(b_rd2),
        .rd_busy1(b_bz1), .rd_busy2(b_bz2),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_cnt(b_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit writable(int c);
        return wr_en && (wr_addr != 0 || !zr[c]);
    endfunction

    function automatic bit [31:0] apply_bytes(bit [31:0] old);
        bit [31:0] d = old;
        for (int k = 0; k < 4; k++)
            if (wr_be[k]) d[8*k +: 8] = wr_data[8*k +: 8];
        return d;
    endfunction

    function automatic bit [31:0] exp_data(int c, int addr);
        if (zr[c] && addr == 0) return 0;
        if (by[c] && writable(c) && int'(wr_addr) == addr)
            return apply_bytes(m_mem[c][addr]);
        return m_mem[c][addr];
    endfunction

    function automatic bit exp_busy(int c, int addr);
        if (zr[c] && addr == 0) return 0;
        if (by[c] && writable(c) && int'(wr_addr) == addr) return 0;
        return m_busy[c][addr];
    endfunction

    function automatic int exp_cnt(int c);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[c][i]);
        return n;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 32; i++) begin
                m_mem[c][i]  = 0;
                m_busy[c][i] = 0;
            end
    endfunction

    function automatic void model_edge();
        if (rst) return;
        for (int c = 0; c < 2; c++) begin
            if (writable(c)) begin
                m_mem[c][wr_addr]  = apply_bytes(m_mem[c][wr_addr]);
                m_busy[c][wr_addr] = 0;
            end
            if (iss_en && (iss_addr != 0 || !zr[c]))
                m_busy[c][iss_addr] = 1;
        end
    endfunction

    task automatic check_all(input string tag);
        int a1 = int'(rd_addr1);
        int a2 = int'(rd_addr2);
        check({tag, ".a_rd1"}, a_rd1, exp_data(0, a1));
        check({tag, ".a_rd2"}, a_rd2, exp_data(0, a2));
        check({tag, ".a_bz1"}, a_bz1, exp_busy(0, a1));
        check({tag, ".a_bz2"}, a_bz2, exp_busy(0, a2));
        check({tag, ".a_cnt"}, a_cnt, exp_cnt(0));
        check({tag, ".b_rd1"}, b_rd1, exp_data(1, a1));
        check({tag, ".b_rd2"}, b_rd2, exp_data(1, a2));
        check({tag, ".b_bz1"}, b_bz1, exp_busy(1, a1));
        check({tag, ".b_bz2"}, b_bz2, exp_busy(1, a2));
        check({tag, ".b_cnt"}, b_cnt, exp_cnt(1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        iss_en = 1'b0;
        wr_be  = 4'h0;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        rst = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0;
        wr_addr = '0; wr_data = '0; iss_addr = '0;
        idle();
        model_clear();
        repeat (2) tick();
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(31 - i);
            #1;
            check_all("reset_read");
        end

        // Full write then low-byte merge on reg 5.
        rd_addr1 = 5'd5; rd_addr2 = 5'd6;
        wr_en = 1'b1; wr_addr = 5'd5;
        wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        #1;
        check("fwd_r5", a_rd1, 32'hDEADBEEF);
        check_all("w5_full");
        tick();
        wr_data = 32'h000000AA; wr_be = 4'h1;
        tick();
        idle();
        #1;
        check("merge_a", a_rd1, 32'hDEADBEAA);
        check("merge_b", b_rd1, 32'hDEADBEAA);
        check_all("w5_merge");

        // Register 0 hard-wiring.
        wr_en = 1'b1; wr_addr = 5'd0;
        wr_data = 32'h12345678; wr_be = 4'hF;
        tick();
        idle();
        rd_addr1 = 5'd0;
        #1;
        check("r0_zero", a_rd1, 32'h0);
        check("r0_live", b_rd1, 32'h12345678);
        check_all("r0");

        // Forwarding vs registered visibility.
        rd_addr1 = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7;
        wr_data = 32'hCAFEF00D; wr_be = 4'hF;
        #1;
        check("byp_new", a_rd1, 32'hCAFEF00D);
        check("nobyp_old", b_rd1, 32'h0);
        check_all("byp_pre");
        tick();
        idle();
        #1;
        check("nobyp_new", b_rd1, 32'hCAFEF00D);
        check_all("byp_post");

        // Scoreboard: issue 3 and 4, write+issue 3, then write 4.
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        iss_addr = 5'd4;
        tick();
        idle();
        #1;
        check("cnt2", a_cnt, 6'd2);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1; wr_be = 4'hF;
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        idle();
        rd_addr1 = 5'd3;
        #1;
        check("bz3_issue_wins", a_bz1, 1'b1);
        check("cnt2_tie", a_cnt, 6'd2);
        check_all("sb_tie");
        wr_en = 1'b1; wr_addr = 5'd4; wr_be = 4'h0;
        tick();
        idle();
        #1;
        check("cnt1", a_cnt, 6'd1);
        check_all("sb_clr");

        // Asynchronous reset between edges, issue held through it.
        wr_en = 1'b1; wr_addr = 5'd9;
        wr_data = 32'h55AA55AA; wr_be = 4'hF;
        tick();
        wr_en = 1'b0;
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        iss_addr = 5'd10;
        rd_addr1 = 5'd9; rd_addr2 = 5'd10;
        #2;
        check("r9_busy", a_bz1, 1'b1);
        rst = 1'b1;
        #1;
        model_clear();
        check("rst_cnt", a_cnt, 6'd0);
        check("rst_r9", a_rd1, 32'h0);
        check_all("rst_async");
        tick();
        check_all("rst_hold");
        rst = 1'b0;
        tick();
        iss_en = 1'b0;
        #1;
        check("post_rst_iss", a_cnt, 6'd1);
        check_all("post_rst");

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rd_addr1 = rnd_addr();
            rd_addr2 = ($urandom_range(0, 7) == 0) ? rd_addr1 : rnd_addr();
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = rnd_addr();
            wr_data  = $urandom;
            wr_be    = 4'($urandom_range(0, 15));
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = ($urandom_range(0, 5) == 0) ? wr_addr : rnd_addr();
            if ($urandom_range(0, 299) == 0) begin
                wr_en = 1'b0;
                #2;
                rst = 1'b1;
                #1;
                model_clear();
                check_all("rnd_rst");
                tick();
                rst = 1'b0;
            end else begin
                #1;
                check_all("rnd");
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
